// File: rtl/sonic_tx_word_feeder.sv
// TX buffer drain: one 40-bit word per clock to the serializer, IDLE_PATTERN fill when dry.
// Define SONIC_TX_UNDERFLOW_CNT_EN to build the saturating underflow counter at 0x0C.
module sonic_tx_word_feeder #(
  parameter int                    DATA_WIDTH   = 40,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0,
  parameter logic [3:0]            PRIME_WAIT   = 4'd4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] buf_data,
  input  logic                  buf_empty,
  input  logic                  buf_almost_empty,
  output logic                  buf_rdreq,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_is_idle,
  input  logic                  tx_prg_wrena,
  input  logic [31:0]           tx_prg_wrdata,
  input  logic [7:0]            tx_prg_addr,
  output logic [31:0]           tx_prg_rddata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      state;
  logic        enable;
  logic        rd_pending;
  logic [3:0]  prime_cnt;
  logic [31:0] word_cnt;
  logic [31:0] underflow_cnt;
  logic        ctrl_wr;
  logic        enable_nxt;
  logic        clr;
  logic        unused_wrdata;

  assign ctrl_wr       = tx_prg_wrena && (tx_prg_addr == 8'h00);
  // A CTRL write steers the FSM on the same edge that updates the enable bit.
  assign enable_nxt    = ctrl_wr ? tx_prg_wrdata[0] : enable;
  assign clr           = ctrl_wr && tx_prg_wrdata[1];
  assign buf_rdreq     = (state == ST_RUN) && !buf_empty;
  assign unused_wrdata = ^tx_prg_wrdata[31:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      enable    <= 1'b0;
      prime_cnt <= '0;
    end else begin
      enable <= enable_nxt;
      if (!enable_nxt) begin
        state     <= ST_IDLE;
        prime_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
          end
          ST_PRIME: begin
            if (buf_almost_empty) begin
              prime_cnt <= '0;
            end else if (prime_cnt + 4'd1 == PRIME_WAIT) begin
              state     <= ST_RUN;
              prime_cnt <= '0;
            end else begin
              prime_cnt <= prime_cnt + 4'd1;
            end
          end
          ST_RUN: begin
            if (buf_empty) state <= ST_PRIME;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // A request issued in any cycle is always delivered one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pending      <= 1'b0;
      tx_data         <= IDLE_PATTERN;
      tx_data_is_idle <= 1'b1;
      word_cnt        <= '0;
    end else begin
      rd_pending <= buf_rdreq;
      if (rd_pending) begin
        tx_data         <= buf_data;
        tx_data_is_idle <= 1'b0;
      end else begin
        tx_data         <= IDLE_PATTERN;
        tx_data_is_idle <= 1'b1;
      end
      if (clr)             word_cnt <= '0;
      else if (rd_pending) word_cnt <= word_cnt + 32'd1;
    end
  end

`ifdef SONIC_TX_UNDERFLOW_CNT_EN
  logic underflow;
  assign underflow = (state == ST_RUN) && buf_empty && enable_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                         underflow_cnt <= '0;
    else if (clr)                                      underflow_cnt <= '0;
    else if (underflow && (underflow_cnt != 32'hFFFF_FFFF)) underflow_cnt <= underflow_cnt + 32'd1;
  end
`else
  assign underflow_cnt = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_prg_rddata <= '0;
    end else begin
      case (tx_prg_addr)
        8'h00:   tx_prg_rddata <= {31'd0, enable};
        8'h04:   tx_prg_rddata <= {29'd0, buf_empty, state};
        8'h08:   tx_prg_rddata <= word_cnt;
        8'h0C:   tx_prg_rddata <= underflow_cnt;
        default: tx_prg_rddata <= '0;
      endcase
    end
  end

endmodule

// File: doc/sonic_tx_word_feeder.md
# sonic_tx_word_feeder

Downstream consumer of the TX circular buffer: pulls 40-bit words from the buffer read port and presents one 40-bit word per clock to the serializer (PMA) interface. When the buffer runs dry it substitutes a fixed idle pattern, so the line never stalls. It tracks underflow events and transmitted-word counts, and exposes control and status through the 8-bit-address program-register port used across the TX path.

## Interface
- DATA_WIDTH, 40, width of buffer words and serializer words
- IDLE_PATTERN, 40'h00_0000_0000, word driven whenever no buffer data is available
- PRIME_WAIT, 4, cycles `buf_almost_empty` must be low before RUN starts (4-bit range, 1..15)

Ports:
- clock  in  1  single clock, the buffer read clock domain
- reset  in  1  asynchronous, active-high
- buf_data  in  40  buffer read data; valid 1 cycle after `buf_rdreq`
- buf_empty  in  1  buffer empty flag
- buf_almost_empty  in  1  buffer almost-empty flag
- buf_rdreq  out  1  read request, one word per asserted cycle
- tx_data  out  40  registered word to serializer, every cycle
- tx_data_is_idle  out  1  high when `tx_data` carries IDLE_PATTERN
- tx_prg_wrena  in  1  register write strobe
- tx_prg_wrdata  in  32  register write data
- tx_prg_addr  in  8  register byte address
- tx_prg_rddata  out  32  register read data, 1-cycle latency

## Operation
- Registers:
  - 0x00 CTRL: bit0 `enable` (R/W); bit1 `clr` (write-1, self-clearing, reads 0).
  - 0x04 STATUS: bits[1:0] state, IDLE=0, PRIME=1, RUN=2; bit2 `buf_empty`.
  - 0x08 WORD_CNT: 32-bit count of buffer words driven on `tx_data`; wraps modulo 2^32.
  - 0x0C UNDERFLOW_CNT: see Configuration.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM:
  - IDLE: `buf_rdreq`=0. Go to PRIME when `enable`=1.
  - PRIME: `buf_rdreq`=0. A 4-bit prime counter increments while `buf_almost_empty`=0 and resets to 0 when it is 1. Go to RUN when the counter reaches PRIME_WAIT.
  - RUN: `buf_rdreq` = ~`buf_empty` (combinational from the registered state).
    - If `buf_empty`=1 while in RUN, this is an underflow: go to PRIME and count it.
- Leaving any state to IDLE: `enable`=0 sends the FSM to IDLE from any state on the next edge.
- Output path:
  - A 1-bit `rd_pending` register records `buf_rdreq`.
  - When `rd_pending`=1, the next `tx_data` = `buf_data` and `tx_data_is_idle`=0; WORD_CNT increments.
  - Otherwise `tx_data` = IDLE_PATTERN and `tx_data_is_idle`=1.
- In-flight read: a read issued in the cycle that `enable` drops, or in the cycle an underflow is detected, is still delivered. It is never dropped.
- `clr` clears WORD_CNT and UNDERFLOW_CNT. If `clr` and an increment occur in the same cycle, the clear wins (result 0).
- Buffer-protocol violations (buffer asserts data with no request) are ignored.

## Timing
- Reset values:
  - `buf_rdreq`=0, `tx_data`=IDLE_PATTERN, `tx_data_is_idle`=1, `tx_prg_rddata`=0.
  - FSM in IDLE; `enable`=0; all counters 0.
- Latency:
  - `buf_rdreq` at edge N, then `buf_data` sampled at edge N+1, then on `tx_data` after edge N+1 (2 cycles from request to output).
  - Register read: address in cycle N, data valid after edge N+1.
  - Register write takes effect at edge N+1.
- Start-up: `enable` written at N gives PRIME at N+1. RUN is entered at the earliest PRIME_WAIT edges later, and the first buffer word appears 2 cycles after that.
- Steady state: with the buffer never empty in RUN, one word per cycle, no idle gaps.
- Reset asserted mid-RUN: outputs return to reset values immediately (asynchronously); the in-flight word is lost.

## Configuration
- `SONIC_TX_UNDERFLOW_CNT_EN` defined:
  - UNDERFLOW_CNT at 0x0C is a 32-bit saturating counter (holds at 0xFFFF_FFFF).
  - It increments once per RUN-to-PRIME transition caused by `buf_empty`.
- Not defined: no counter logic is built; 0x0C reads 0.

## Test plan
- Reset, then read 0x00/0x04/0x08 → all 0; `tx_data`=IDLE_PATTERN, `tx_data_is_idle`=1.
- Buffer preloaded with 8 words, `buf_almost_empty`=0, write 0x00=1 → RUN after 4 PRIME cycles; 8 consecutive words exactly 2 cycles after their `buf_rdreq`; then WORD_CNT=8.
- `buf_empty` rises after 3 words in RUN → FSM returns to PRIME; the 3rd word is still output, then IDLE_PATTERN. With the macro, UNDERFLOW_CNT=1; without it, 0x0C reads 0.
- `buf_almost_empty` toggles every 2 cycles during PRIME → FSM stays in PRIME and `buf_rdreq` stays 0.
- Write 0x00=0 in the same cycle as a `buf_rdreq` → the requested word is output and WORD_CNT increments; the FSM is IDLE on the next cycle.
- WORD_CNT forced to 0xFFFF_FFFF and one word sent together with `clr` → reads 0. Without `clr`, the same single word → wraps to 0.
